hit_detector: RTL and testbench
===============================

# hit_detector

Per-frame collision checker between the player's bullet and the moving enemy row. It reads the enemy x position (`posxE1`) from the enemy movement logic and the bullet position from the shot logic. It produces the one-cycle `mueva` hit pulse that drives the movement block's points/speed FSM. It also clears the bullet via `hit_kill` and keeps a saturating hit count for the score display.

## Interface
Parameters:
- `ENEMY_W`, 32, enemy hitbox width in pixels
- `ENEMY_H`, 16, enemy hitbox height in pixels
- `ENEMY_Y`, 60, top row of the enemy hitbox (11-bit)
- `COOL_FRAMES`, 4, frames ignored after a hit (1..15)

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1 system clock
- `reset` input 1 asynchronous, active-low reset
- `posxE1` input 11 enemy left-edge x, from enemy movement logic
- `bulx` input 11 bullet x
- `buly` input 11 bullet y
- `bul_valid` input 1 bullet in flight
- `frame_tick` input 1 one-cycle pulse per video frame
- `mueva` output 1 one-cycle pulse per registered hit
- `hit_kill` output 1 level; request shot logic to retire bullet
- `hits` output 8 saturating hit count
- `busy` output 1 high in HIT or COOL state

## Operation
- States: IDLE, TRACK, HIT, COOL. Reset state is IDLE.
- IDLE -> TRACK when `bul_valid`=1.
- TRACK:
  - On `frame_tick`, capture `posxE1`, `bulx` and `buly` into sample registers (stage S). This freezes the enemy position for the whole comparison.
  - Next cycle (stage C), evaluate the overlap: `bulx >= px` and `bulx < px+ENEMY_W` and `buly >= ENEMY_Y` and `buly < ENEMY_Y+ENEMY_H`.
  - All sums are computed at 12 bits, so `px+ENEMY_W` never wraps. An enemy at x=2040 still has a 32-pixel box.
  - The overlap result is registered. Overlap=1 -> HIT; overlap=0 -> stay in TRACK.
- HIT:
  - `mueva`=1 only on the first cycle in HIT.
  - `hits` increments on that same edge and saturates at 255; `mueva` still pulses at saturation.
  - `hit_kill` holds 1 until `bul_valid`=0, then the FSM moves to COOL.
- COOL: count `COOL_FRAMES` frame_ticks with a 4-bit counter, then go to IDLE.
- `bul_valid` falling in TRACK:
  - Return to IDLE and discard any pending S/C stage; no hit is reported.
  - If the fall coincides with `frame_tick`, the fall wins: no sample is taken.
- A new `frame_tick` arriving while the C stage is pending is ignored. One comparison runs per frame.
- Reset mid-operation returns the FSM to IDLE immediately and clears all outputs and counters.

## Timing
- Reset values: `mueva`=0, `hit_kill`=0, `hits`=0, `busy`=0. State=IDLE, cool counter=0, sample registers=0.
- Latency, with `frame_tick` high at edge N in TRACK:
  - Samples are registered at N.
  - Overlap is registered at N+1.
  - At N+2 the state is HIT; `mueva`=1, `hit_kill`=1 and `busy`=1 are all visible from N+2, and `hits` is updated at N+2.
- `mueva` falls at N+3.
- `hit_kill` falls on the edge after `bul_valid`=0 is sampled, and the state becomes COOL on that same edge.
- Cooldown: `busy` stays high through the COOL_FRAMES-th `frame_tick` in COOL. The state is IDLE one cycle after that tick.
- All outputs are registered; none is combinational from the inputs.

## Configuration
- `HIT_COOLDOWN_EN`
  - Defined: COOL state and frame counter are present, as described above.
  - Undefined: HIT goes directly to IDLE when `bul_valid`=0. The counter logic is removed, and `busy` is high only in HIT.

## Test plan
- Centre hit: `posxE1`=100, bullet (116, 68), `bul_valid`=1, one `frame_tick` -> `mueva` pulses at tick+2 for 1 cycle, `hits`=1, `hit_kill`=1 until `bul_valid` drops.
- Edge miss/hit: bullet x=132 with px=100 -> no hit; x=131 -> hit. Bullet y=76 -> no hit; y=75 -> hit.
- No wrap: `posxE1`=2040, bullet x=2047, y=60 -> hit. Same with `posxE1`=2, bullet x=1 -> no hit.
- Abort: `bul_valid` falls on the same cycle as `frame_tick` over an overlapping position -> no `mueva`, state IDLE, `hits` unchanged.
- Cooldown (macro defined, COOL_FRAMES=4): a second overlapping bullet arrives 2 frames after the first hit -> ignored. The same bullet arriving after the 4th tick -> hit counted. With the macro undefined, the 2-frame case is counted.
- Saturation and reset: 256 hits -> `hits`=255 and `mueva` still pulses. `reset`=0 asserted while in HIT -> all outputs 0 asynchronously and the state is IDLE.

Source files
------------

// File: rtl/hit_detector.sv
// Bullet/enemy collision checker: frame-sampled overlap test, hit pulse, bullet retire and saturating hit count.
// Optional HIT_COOLDOWN_EN adds a COOL state that ignores COOL_FRAMES frames after each hit.
module hit_detector #(
  parameter int unsigned ENEMY_W     = 32,
  parameter int unsigned ENEMY_H     = 16,
  parameter logic [10:0] ENEMY_Y     = 11'd60,
  parameter int unsigned COOL_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] posxE1,
  input  logic [10:0] bulx,
  input  logic [10:0] buly,
  input  logic        bul_valid,
  input  logic        frame_tick,
  output logic        mueva,
  output logic        hit_kill,
  output logic [7:0]  hits,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TRACK, HIT, COOL} state_t;

  localparam logic [11:0] W12  = 12'(ENEMY_W);
  localparam logic [11:0] Y_LO = {1'b0, ENEMY_Y};
  localparam logic [11:0] Y_HI = {1'b0, ENEMY_Y} + 12'(ENEMY_H);

  if (COOL_FRAMES < 1 || COOL_FRAMES > 15) begin : g_bad_cfg
    $error("hit_detector: COOL_FRAMES must be in 1..15");
  end

  state_t      state, state_n;
  logic [10:0] spx, sbx, sby;
  logic        s_pend, c_pend, ovl;
  logic        sample_en, eval_en, overlap;

`ifdef HIT_COOLDOWN_EN
  localparam logic [3:0] CF_LAST = 4'(COOL_FRAMES - 1);
  logic [3:0] cool_cnt;
`endif

  // Comparison runs on the frozen samples at 12 bits so px+ENEMY_W cannot wrap.
  always_comb begin
    overlap = ({1'b0, sbx} >= {1'b0, spx}) &&
              ({1'b0, sbx} <  ({1'b0, spx} + W12)) &&
              ({1'b0, sby} >= Y_LO) &&
              ({1'b0, sby} <  Y_HI);
  end

  always_comb begin
    state_n   = state;
    sample_en = 1'b0;
    eval_en   = 1'b0;
    case (state)
      IDLE: if (bul_valid) state_n = TRACK;
      TRACK: begin
        if (!bul_valid) begin
          state_n = IDLE;
        end else begin
          sample_en = frame_tick && !s_pend && !c_pend;
          eval_en   = s_pend;
          if (c_pend && ovl) state_n = HIT;
        end
      end
      HIT: begin
`ifdef HIT_COOLDOWN_EN
        if (!bul_valid) state_n = COOL;
`else
        if (!bul_valid) state_n = IDLE;
`endif
      end
`ifdef HIT_COOLDOWN_EN
      COOL: if (frame_tick && cool_cnt == CF_LAST) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // S/C pipeline: pending flags clear whenever TRACK is left, discarding any in-flight compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spx    <= '0;
      sbx    <= '0;
      sby    <= '0;
      s_pend <= 1'b0;
      c_pend <= 1'b0;
      ovl    <= 1'b0;
    end else begin
      s_pend <= sample_en;
      c_pend <= eval_en;
      if (sample_en) begin
        spx <= posxE1;
        sbx <= bulx;
        sby <= buly;
      end
      if (eval_en) ovl <= overlap;
    end
  end

`ifdef HIT_COOLDOWN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cool_cnt <= '0;
    end else if (state == COOL) begin
      if (frame_tick) cool_cnt <= (cool_cnt == CF_LAST) ? '0 : cool_cnt + 4'd1;
    end else begin
      cool_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mueva    <= 1'b0;
      hit_kill <= 1'b0;
      hits     <= '0;
      busy     <= 1'b0;
    end else begin
      mueva    <= (state_n == HIT) && (state != HIT);
      hit_kill <= (state_n == HIT);
`ifdef HIT_COOLDOWN_EN
      busy     <= (state_n == HIT) || (state_n == COOL);
`else
      busy     <= (state_n == HIT);
`endif
      if ((state_n == HIT) && (state != HIT) && (hits != '1)) hits <= hits + 8'd1;
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector: latency, hitbox edges, abort, cooldown, saturation and async reset.
module tb_hit_detector;
  localparam int unsigned COOL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] posxE1, bulx, buly;
  logic        bul_valid, frame_tick;
  logic        mueva, hit_kill, busy;
  logic [7:0]  hits;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hits = 0;

  hit_detector #(.ENEMY_W(32), .ENEMY_H(16), .ENEMY_Y(11'd60), .COOL_FRAMES(COOL)) dut (
    .clk(clk), .reset(reset), .posxE1(posxE1), .bulx(bulx), .buly(buly),
    .bul_valid(bul_valid), .frame_tick(frame_tick),
    .mueva(mueva), .hit_kill(hit_kill), .hits(hits), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic bump_exp();
    if (exp_hits < 255) exp_hits++;
  endtask

  // One bullet: launch, one frame tick, observe N+1..N+3, retire, drain cooldown after a hit.
  task automatic shot(input logic [10:0] px, input logic [10:0] bx, input logic [10:0] by,
                      output logic m1, output logic m2, output logic m3, output logic k2,
                      output logic k3, output logic kd, output logic b2, output logic [7:0] h2);
    posxE1 = px; bulx = bx; buly = by; bul_valid = 1'b1;
    step();
    pulse_tick();
    step(); m1 = mueva;
    step(); m2 = mueva; k2 = hit_kill; b2 = busy; h2 = hits;
    step(); m3 = mueva; k3 = hit_kill;
    bul_valid = 1'b0;
    step(); kd = hit_kill;
`ifdef HIT_COOLDOWN_EN
    if (m2) repeat (COOL) pulse_tick();
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; posxE1 = '0; bulx = '0; buly = '0; bul_valid = 1'b0; frame_tick = 1'b0;
    #12;
    n_cmp++; if (mueva !== 1'b0) begin n_bad++; $display("FAIL reset_mueva: got %b want 0", mueva); end
    n_cmp++; if (hit_kill !== 1'b0) begin n_bad++; $display("FAIL reset_hit_kill: got %b want 0", hit_kill); end
    n_cmp++; if (hits !== 8'd0) begin n_bad++; $display("FAIL reset_hits: got %0d want 0", hits); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); reset = 1'b1;
    step();
  endtask

  task automatic test_centre_hit();
    logic m1, m2, m3, k2, k3, kd, b2;
    logic [7:0] h2;
    shot(11'd100, 11'd116, 11'd68, m1, m2, m3, k2, k3, kd, b2, h2);
    bump_exp();
    n_cmp++; if (m1 !== 1'b0) begin n_bad++; $display("FAIL centre_mueva_n1: got %b want 0", m1); end
    n_cmp++; if (m2 !== 1'b1) begin n_bad++; $display("FAIL centre_mueva_n2: got %b want 1", m2); end
    n_cmp++; if (m3 !== 1'b0) begin n_bad++; $display("FAIL centre_mueva_n3: got %b want 0", m3); end
    n_cmp++; if (k2 !== 1'b1) begin n_bad++; $display("FAIL centre_kill_n2: got %b want 1", k2); end
    n_cmp++; if (k3 !== 1'b1) begin n_bad++; $display("FAIL centre_kill_hold: got %b want 1", k3); end
    n_cmp++; if (kd !== 1'b0) begin n_bad++; $display("FAIL centre_kill_drop: got %b want 0", kd); end
    n_cmp++; if (b2 !== 1'b1) begin n_bad++; $display("FAIL centre_busy: got %b want 1", b2); end
    n_cmp++; if (h2 !== 8'(exp_hits)) begin n_bad++; $display("FAIL centre_hits: got %0d want %0d", h2, exp_hits); end
  endtask

  task automatic test_edges();
    logic [10:0] vpx [10] = '{11'd100, 11'd100, 11'd100, 11'd100, 11'd100, 11'd100, 11'd100, 11'd100, 11'd2040, 11'd2};
    logic [10:0] vbx [10] = '{11'd132, 11'd131, 11'd100, 11'd99, 11'd116, 11'd116, 11'd116, 11'd116, 11'd2047, 11'd1};
    logic [10:0] vby [10] = '{11'd68, 11'd68, 11'd68, 11'd68, 11'd76, 11'd75, 11'd60, 11'd59, 11'd60, 11'd60};
    logic        vht [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic m1, m2, m3, k2, k3, kd, b2;
    logic [7:0] h2;
    for (int i = 0; i < 10; i++) begin
      shot(vpx[i], vbx[i], vby[i], m1, m2, m3, k2, k3, kd, b2, h2);
      if (vht[i]) bump_exp();
      n_cmp++; if (m2 !== vht[i]) begin n_bad++; $display("FAIL edge%0d_mueva px=%0d x=%0d y=%0d: got %b want %b", i, vpx[i], vbx[i], vby[i], m2, vht[i]); end
      n_cmp++; if (h2 !== 8'(exp_hits)) begin n_bad++; $display("FAIL edge%0d_hits: got %0d want %0d", i, h2, exp_hits); end
    end
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    posxE1 = 11'd100; bulx = 11'd116; buly = 11'd68; bul_valid = 1'b1;
    step();
    frame_tick = 1'b1; bul_valid = 1'b0;
    step();
    frame_tick = 1'b0;
    repeat (4) begin step(); seen |= mueva; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_mueva: got %b want 0", seen); end
    n_cmp++; if (hits !== 8'(exp_hits)) begin n_bad++; $display("FAIL abort_hits: got %0d want %0d", hits, exp_hits); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_tick_during_pending();
    logic seen = 1'b0;
    posxE1 = 11'd100; bulx = 11'd132; buly = 11'd68; bul_valid = 1'b1;
    step();
    pulse_tick();
    bulx = 11'd116;
    pulse_tick(); seen |= mueva;
    repeat (3) begin step(); seen |= mueva; end
    bul_valid = 1'b0;
    step();
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL pending_tick_ignored: got %b want 0", seen); end
    n_cmp++; if (hits !== 8'(exp_hits)) begin n_bad++; $display("FAIL pending_hits: got %0d want %0d", hits, exp_hits); end
  endtask

  task automatic test_cooldown();
    logic seen = 1'b0;
    posxE1 = 11'd100; bulx = 11'd116; buly = 11'd68; bul_valid = 1'b1;
    step(); pulse_tick(); step(); step();
    bump_exp();
    n_cmp++; if (mueva !== 1'b1) begin n_bad++; $display("FAIL cool_first_mueva: got %b want 1", mueva); end
    bul_valid = 1'b0;
    step();
    bul_valid = 1'b1;
    step();
    pulse_tick(); seen |= mueva; step(); seen |= mueva; step(); seen |= mueva;
    pulse_tick(); seen |= mueva; step(); seen |= mueva; step(); seen |= mueva;
`ifdef HIT_COOLDOWN_EN
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL cool_ignored: got %b want 0", seen); end
    n_cmp++; if (hits !== 8'(exp_hits)) begin n_bad++; $display("FAIL cool_hits_held: got %0d want %0d", hits, exp_hits); end
    pulse_tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cool_busy_tick3: got %b want 1", busy); end
    pulse_tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cool_busy_tick4: got %b want 0", busy); end
    step();
    pulse_tick(); step(); step();
    bump_exp();
    n_cmp++; if (mueva !== 1'b1) begin n_bad++; $display("FAIL cool_after_mueva: got %b want 1", mueva); end
    n_cmp++; if (hits !== 8'(exp_hits)) begin n_bad++; $display("FAIL cool_after_hits: got %0d want %0d", hits, exp_hits); end
    bul_valid = 1'b0;
    step();
    repeat (COOL) pulse_tick();
`else
    bump_exp();
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL nocool_counted: got %b want 1", seen); end
    n_cmp++; if (hits !== 8'(exp_hits)) begin n_bad++; $display("FAIL nocool_hits: got %0d want %0d", hits, exp_hits); end
    bul_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nocool_busy: got %b want 0", busy); end
`endif
  endtask

  task automatic test_saturation();
    logic m1, m2, m3, k2, k3, kd, b2;
    logic [7:0] h2;
    while (exp_hits < 255) begin
      shot(11'd100, 11'd116, 11'd68, m1, m2, m3, k2, k3, kd, b2, h2);
      bump_exp();
    end
    n_cmp++; if (hits !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d want 255", hits); end
    shot(11'd100, 11'd116, 11'd68, m1, m2, m3, k2, k3, kd, b2, h2);
    bump_exp();
    n_cmp++; if (m2 !== 1'b1) begin n_bad++; $display("FAIL sat_mueva: got %b want 1", m2); end
    n_cmp++; if (h2 !== 8'd255) begin n_bad++; $display("FAIL sat_hits: got %0d want 255", h2); end
  endtask

  task automatic test_reset_in_hit();
    posxE1 = 11'd100; bulx = 11'd116; buly = 11'd68; bul_valid = 1'b1;
    step(); pulse_tick(); step(); step();
    n_cmp++; if (hit_kill !== 1'b1) begin n_bad++; $display("FAIL rst_pre_kill: got %b want 1", hit_kill); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (mueva !== 1'b0) begin n_bad++; $display("FAIL rst_async_mueva: got %b want 0", mueva); end
    n_cmp++; if (hit_kill !== 1'b0) begin n_bad++; $display("FAIL rst_async_kill: got %b want 0", hit_kill); end
    n_cmp++; if (hits !== 8'd0) begin n_bad++; $display("FAIL rst_async_hits: got %0d want 0", hits); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    step();
    bul_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    step();
    exp_hits = 0;
    bul_valid = 1'b1;
    step(); pulse_tick(); step(); step();
    bump_exp();
    n_cmp++; if (mueva !== 1'b1) begin n_bad++; $display("FAIL rst_after_mueva: got %b want 1", mueva); end
    n_cmp++; if (hits !== 8'(exp_hits)) begin n_bad++; $display("FAIL rst_after_hits: got %0d want %0d", hits, exp_hits); end
    bul_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_centre_hit();
    test_edges();
    test_abort();
    test_tick_during_pending();
    test_cooldown();
    test_saturation();
    test_reset_in_hit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
